// File: rtl/gpioemu_mulcnt_if.sv
// gpioemu_mulcnt_if: saddress/srd/swr slave register bus of the multiply/popcount coprocessor.
interface gpioemu_mulcnt_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  modport master(output saddress, srd, swr, sdata_in, input sdata_out);
  modport slave(input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/gpioemu_mulcnt.sv
// gpioemu_mulcnt: bus-mapped bit-serial multiply + popcount coprocessor.
// Define MULCNT_SATURATE_EN to saturate W/L when the product overflows RESW bits.
module gpioemu_mulcnt #(
  parameter int          OPW       = 24,
  parameter int          RESW      = 32,
  parameter int          CNTW      = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic                   clk,
  input  logic                   n_reset,
  gpioemu_mulcnt_if.slave        bus,
  input  logic [31:0]            gpio_in,
  input  logic                   gpio_latch,
  output logic [31:0]            gpio_out,
  output logic [31:0]            gpio_in_s_insp
);
  localparam int PW = 2 * OPW;
  localparam int BW = (OPW > 1) ? $clog2(OPW) : 1;
  localparam int LW = $clog2(RESW + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, COUNT = 2'd2, DONE = 2'd3} state_e;
  state_e          state_q, state_d;
  logic [OPW-1:0]  a1_q, a1_d, a2_q, a2_d, mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [RESW-1:0] w_q, w_d, w_new;
  logic [LW-1:0]   l_q, l_d, pop;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d, done_q, done_d, valid_q, valid_d, ovf;
  logic            srd_q, swr_q, latch_q;
  logic [31:0]     sdata_q, sdata_d, gin_q, gin_d, rdata;
  logic            rd_rise, wr_rise, hit_a1, hit_a2, hit_ctrl;
  logic            unused_ok;
  assign rd_rise  = bus.srd & ~srd_q;
  assign wr_rise  = bus.swr & ~swr_q;
  assign hit_a1   = bus.saddress == BASE_ADDR;
  assign hit_a2   = bus.saddress == BASE_ADDR + 16'h08;
  assign hit_ctrl = bus.saddress == BASE_ADDR + 16'h20;
  assign unused_ok = ^bus.sdata_in;
  assign ovf = |(acc_q >> RESW);
`ifdef MULCNT_SATURATE_EN
  assign w_new = ovf ? '1 : acc_q[RESW-1:0];
`else
  assign w_new = acc_q[RESW-1:0];
`endif
  always_comb begin
    pop = '0;
    for (int i = 0; i < RESW; i++) pop = pop + LW'(w_new[i]);
  end
  always_comb begin
    rdata = hit_a1                            ? 32'(a1_q) :
            hit_a2                            ? 32'(a2_q) :
            bus.saddress == BASE_ADDR + 16'h10 ? 32'(w_q) :
            bus.saddress == BASE_ADDR + 16'h18 ? 32'(l_q) :
            hit_ctrl                          ? {29'b0, err_q, done_q, valid_q} :
            bus.saddress == BASE_ADDR + 16'h24 ? 32'(state_q) :
            bus.saddress == BASE_ADDR + 16'h28 ? 32'(cnt_q) : 32'h0;
  end
  always_comb begin
    state_d  = state_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    bit_d    = bit_q;
    w_d      = w_q;
    l_d      = l_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = done_q;
    valid_d  = valid_q;
    sdata_d  = rd_rise ? rdata : sdata_q;
    gin_d    = (gpio_latch & ~latch_q) ? gpio_in : gin_q;
    // Operand writes and start are refused while a job runs and flag err instead.
    if (wr_rise && (hit_a1 || hit_a2 || hit_ctrl)) begin
      if (state_q != IDLE) err_d = 1'b1;
      else if (hit_a1) a1_d = bus.sdata_in[OPW-1:0];
      else if (hit_a2) a2_d = bus.sdata_in[OPW-1:0];
      else begin
        state_d  = MULT;
        done_d   = 1'b0;
        err_d    = 1'b0;
        acc_d    = '0;
        mcand_d  = PW'(a1_q);
        mplier_d = a2_q;
        bit_d    = '0;
      end
    end
    case (state_q)
      MULT: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + BW'(1);
        state_d  = (bit_q == BW'(OPW - 1)) ? COUNT : MULT;
      end
      COUNT: begin
        valid_d = ~ovf;
        w_d     = w_new;
        l_d     = pop;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNTW'(1);
        state_d = IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      a1_q     <= '0;
      a2_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      bit_q    <= '0;
      w_q      <= '0;
      l_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b1;
      valid_q  <= 1'b1;
      srd_q    <= 1'b0;
      swr_q    <= 1'b0;
      latch_q  <= 1'b0;
      sdata_q  <= '0;
      gin_q    <= '0;
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      bit_q    <= bit_d;
      w_q      <= w_d;
      l_q      <= l_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      srd_q    <= bus.srd;
      swr_q    <= bus.swr;
      latch_q  <= gpio_latch;
      sdata_q  <= sdata_d;
      gin_q    <= gin_d;
    end
  end
  assign bus.sdata_out   = sdata_q;
  assign gpio_out        = 32'(cnt_q);
  assign gpio_in_s_insp  = gin_q;
endmodule

// File: tb/tb_gpioemu_mulcnt.sv
// tb_gpioemu_mulcnt: random + directed bench against a cycle-count job model of the coprocessor.
module tb_gpioemu_mulcnt;
  localparam logic [15:0] B = 16'h0380;
  logic        clk = 1'b0, n_reset = 1'b1, gpio_latch = 1'b0;
  logic [31:0] gpio_in = '0, gpio_out, gpio_in_s_insp, gpio_out2, gin2;
  int          vec = 0, bad = 0;
  bit          chk_en = 1'b0;
  gpioemu_mulcnt_if bus();
  gpioemu_mulcnt_if bus2();
  gpioemu_mulcnt dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
  );
  gpioemu_mulcnt #(.OPW(2), .RESW(4), .CNTW(4)) u2 (
    .clk(clk), .n_reset(n_reset), .bus(bus2), .gpio_in(32'h0), .gpio_latch(1'b0),
    .gpio_out(gpio_out2), .gpio_in_s_insp(gin2)
  );
  always #5 clk = ~clk;
  logic [31:0] m_a1 = '0, m_a2 = '0, m_w = '0, m_rd = '0, m_gs = '0;
  logic [63:0] m_prod = '0;
  logic [15:0] m_cnt = '0;
  int          m_l = 0, m_t = 0;
  bit          m_err = 0, m_done = 1, m_valid = 1, m_busy = 0, p_rd = 0, p_wr = 0, p_lt = 0;
  function automatic logic [31:0] mread(input logic [15:0] a);
    int st = !m_busy ? 0 : (m_t < 24) ? 1 : (m_t == 24) ? 2 : 3;
    case (a)
      B:          return m_a1;
      B + 16'h08: return m_a2;
      B + 16'h10: return m_w;
      B + 16'h18: return 32'(m_l);
      B + 16'h20: return {29'b0, m_err, m_done, m_valid};
      B + 16'h24: return 32'(st);
      B + 16'h28: return {16'b0, m_cnt};
      default:    return 32'h0;
    endcase
  endfunction
  // Job model: product computed at start, results appear by elapsed-cycle count.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_a1 = 0; m_a2 = 0; m_w = 0; m_l = 0; m_cnt = 0; m_rd = 0; m_gs = 0;
      m_err = 0; m_done = 1; m_valid = 1; m_busy = 0; m_t = 0;
      p_rd = 0; p_wr = 0; p_lt = 0;
    end else begin
      bit busy;
      busy = m_busy;
      if (bus.srd && !p_rd) m_rd = mread(bus.saddress);
      if (gpio_latch && !p_lt) m_gs = gpio_in;
      if (m_busy) begin
        m_t++;
        if (m_t == 25) begin
          m_valid = (m_prod >> 32) == 0;
`ifdef MULCNT_SATURATE_EN
          m_w = m_valid ? m_prod[31:0] : 32'hFFFFFFFF;
`else
          m_w = m_prod[31:0];
`endif
          m_l = $countones(m_w);
        end else if (m_t == 26) begin
          m_done = 1;
          m_cnt = m_cnt + 16'd1;
          m_busy = 0;
        end
      end
      if (bus.swr && !p_wr) begin
        if (busy && (bus.saddress == B || bus.saddress == B + 16'h08 || bus.saddress == B + 16'h20))
          m_err = 1;
        else if (bus.saddress == B) m_a1 = bus.sdata_in & 32'h00FFFFFF;
        else if (bus.saddress == B + 16'h08) m_a2 = bus.sdata_in & 32'h00FFFFFF;
        else if (bus.saddress == B + 16'h20) begin
          m_prod = 64'(m_a1) * 64'(m_a2);
          m_done = 0; m_err = 0; m_busy = 1; m_t = 0;
        end
      end
      p_rd = bus.srd; p_wr = bus.swr; p_lt = gpio_latch;
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("sdata_out", bus.sdata_out, m_rd);
    check("gpio_out", gpio_out, {16'b0, m_cnt});
    check("gpio_in_s_insp", gpio_in_s_insp, m_gs);
  end
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus.saddress = a; bus.sdata_in = d; bus.swr = 1'b1;
    @(posedge clk); #2;
    bus.swr = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    @(posedge clk); #2;
    bus.saddress = a; bus.srd = 1'b1;
    @(posedge clk); #2;
    bus.srd = 1'b0;
    v = bus.sdata_out;
  endtask
  initial begin
    logic [31:0] v;
    logic [15:0] a;
    bus.saddress = '0; bus.srd = 0; bus.swr = 0; bus.sdata_in = '0;
    bus2.saddress = '0; bus2.srd = 0; bus2.swr = 0; bus2.sdata_in = '0;
    #1 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_reset = 1'b1;
    chk_en = 1'b1;
    rd(B + 16'h20, v); check("reset STATUS", v, 32'd3);
    rd(B + 16'h24, v); check("reset STATE", v, 32'd0);
    rd(B + 16'h10, v); check("reset W", v, 32'd0);
    rd(B + 16'h18, v); check("reset L", v, 32'd0);
    check("reset gpio_out", gpio_out, 32'd0);
    wr(B, 32'd3); wr(B + 16'h08, 32'd5); wr(B + 16'h20, 32'd0);
    repeat (27) @(posedge clk);
    rd(B + 16'h10, v); check("3x5 W", v, 32'd15);
    rd(B + 16'h18, v); check("3x5 L", v, 32'd4);
    rd(B + 16'h20, v); check("3x5 STATUS", v, 32'd3);
    check("3x5 gpio_out", gpio_out, 32'd1);
    wr(B, 32'h00FFFFFF); wr(B + 16'h08, 32'hFFFFFFFF); wr(B + 16'h20, 32'd0);
    repeat (27) @(posedge clk);
`ifdef MULCNT_SATURATE_EN
    rd(B + 16'h10, v); check("ovf W", v, 32'hFFFFFFFF);
    rd(B + 16'h18, v); check("ovf L", v, 32'd32);
`else
    rd(B + 16'h10, v); check("ovf W", v, 32'hFE000001);
    rd(B + 16'h18, v); check("ovf L", v, 32'd8);
`endif
    rd(B + 16'h20, v); check("ovf STATUS", v, 32'd2);
    wr(B + 16'h20, 32'd0);
    repeat (3) @(posedge clk);
    wr(B + 16'h20, 32'd0);
    rd(B + 16'h20, v); check("busy start STATUS", v, 32'd4);
    wr(B, 32'd7);
    repeat (27) @(posedge clk);
    rd(B, v); check("busy A1 kept", v, 32'h00FFFFFF);
    rd(B + 16'h20, v); check("err end STATUS", v, 32'd6);
    check("err job count", gpio_out, 32'd3);
    wr(B + 16'h20, 32'd0);
    rd(B + 16'h20, v); check("restart clears err", v, 32'd0);
    repeat (27) @(posedge clk);
    wr(B, 32'd3); wr(B + 16'h20, 32'd0);
    repeat (10) @(posedge clk);
    #2 n_reset = 1'b0;
    @(posedge clk); #2 n_reset = 1'b1;
    rd(B + 16'h24, v); check("abort STATE", v, 32'd0);
    rd(B + 16'h20, v); check("abort STATUS", v, 32'd3);
    rd(B + 16'h10, v); check("abort W", v, 32'd0);
    check("abort gpio_out", gpio_out, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      case ($urandom % 10)
        0: a = B;
        1: a = B + 16'h08;
        2, 3: a = B + 16'h20;
        4: a = B + 16'h10;
        5: a = B + 16'h18;
        6: a = B + 16'h24;
        7: a = B + 16'h28;
        8: a = B + 16'h04;
        default: a = 16'($urandom);
      endcase
      bus.saddress = a;
      bus.srd = ($urandom % 3) == 0;
      bus.swr = ($urandom % 6) == 0;
      bus.sdata_in = ($urandom % 2) ? $urandom : ($urandom % 16);
      gpio_latch = ($urandom % 4) == 0;
      gpio_in = $urandom;
      n_reset = ($urandom % 700) != 0;
    end
    @(posedge clk); #2;
    bus.srd = 0; bus.swr = 0; gpio_latch = 0; n_reset = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #2;
      bus2.saddress = B + 16'h20; bus2.swr = 1'b1;
      @(posedge clk); #2;
      bus2.swr = 1'b0;
      repeat (6) @(posedge clk);
      #2 check("wrap gpio_out", gpio_out2, 32'(k % 16));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
